// File: rtl/kbd_ctrl.sv
// kbd_ctrl: PS/2 set-2 scan-code sequencer feeding the seven-segment drivers.
// Decodes E0/F0 prefixes, tracks the held key, drops typematic repeats,
// counts presses and drives the display enables. It also keeps a sticky
// error flag for prefix-protocol and timeout errors.
// Ports:
//   clk, resetn             clock, async active-low reset
//   code_valid, code        one-cycle strobe and the received scan byte
//   err_clr                 clears the sticky error flag
//   key_code, key_ext       last accepted make code and its E0 flag
//   key_held                the key in key_code/key_ext is pressed
//   press_count             accepted new presses, mod 256
//   make_pulse, break_pulse one-cycle press/release strobes
//   code_en, cnt_en         display enables for the code and count digits
//   err                     sticky protocol/timeout error
module kbd_ctrl #(
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       code_valid,
  input  logic [7:0] code,
  input  logic       err_clr,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_held,
  output logic [7:0] press_count,
  output logic       make_pulse,
  output logic       break_pulse,
  output logic       code_en,
  output logic       cnt_en,
  output logic       err
);

  localparam int unsigned BW = 8;
  localparam logic [BW-1:0] PFX_EXT = 8'hE0;
  localparam logic [BW-1:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] key_code_q, key_code_d;
  logic [BW-1:0] press_q, press_d;
  logic          key_ext_q, key_ext_d;
  logic          held_q, held_d;
  logic          make_q, make_d;
  logic          brk_q, brk_d;
  logic          code_en_q;
  logic          cnt_en_q, cnt_en_d;
  logic          err_q, err_d;

  logic          do_make, do_brk, ext, err_set, expire, hit;

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      key_code_q <= '0;
      key_ext_q  <= 1'b0;
      held_q     <= 1'b0;
      press_q    <= '0;
      make_q     <= 1'b0;
      brk_q      <= 1'b0;
      code_en_q  <= 1'b0;
      cnt_en_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_code_q <= key_code_d;
      key_ext_q  <= key_ext_d;
      held_q     <= held_d;
      press_q    <= press_d;
      make_q     <= make_d;
      brk_q      <= brk_d;
      code_en_q  <= held_d;
      cnt_en_q   <= cnt_en_d;
      err_q      <= err_d;
    end
  end

  // Prefix decode, timeout, key tracking and error flag
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_code_d = key_code_q;
    key_ext_d  = key_ext_q;
    held_d     = held_q;
    press_d    = press_q;
    make_d     = 1'b0;
    brk_d      = 1'b0;
    cnt_en_d   = cnt_en_q;
    do_make    = 1'b0;
    do_brk     = 1'b0;
    ext        = 1'b0;
    err_set    = 1'b0;

    // Expires on the edge where the counter would reach TIMEOUT; a strobe wins.
    expire = (state_q != S_IDLE) && !code_valid && (cnt_q == CW'(TIMEOUT - 1));

    if (code_valid) begin
      case (state_q)
        S_IDLE: begin
          if (code == PFX_EXT)      state_d = S_EXT;
          else if (code == PFX_BRK) state_d = S_BRK;
          else                      do_make = 1'b1;
        end
        S_EXT: begin
          if (code == PFX_BRK)      state_d = S_EXT_BRK;
          else if (code == PFX_EXT) err_set = 1'b1;
          else begin
            do_make = 1'b1;
            ext     = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          if (code == PFX_EXT || code == PFX_BRK) err_set = 1'b1;
          else                                    do_brk  = 1'b1;
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          if (code == PFX_EXT || code == PFX_BRK) err_set = 1'b1;
          else begin
            do_brk = 1'b1;
            ext    = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (expire) begin
      state_d = S_IDLE;
      err_set = 1'b1;
    end

    if (code_valid || state_q == S_IDLE || expire) cnt_d = '0;
    else                                            cnt_d = cnt_q + CW'(1);

    hit = held_q && (code == key_code_q) && (ext == key_ext_q);

    // A make matching the held key is a typematic repeat and changes nothing.
    if (do_make && !hit) begin
      key_code_d = code;
      key_ext_d  = ext;
      held_d     = 1'b1;
      press_d    = press_q + BW'(1);
      make_d     = 1'b1;
      cnt_en_d   = 1'b1;
    end

    // Breaks for any key other than the held one are silently ignored.
    if (do_brk && hit) begin
      held_d = 1'b0;
      brk_d  = 1'b1;
    end

    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_held    = held_q;
  assign press_count = press_q;
  assign make_pulse  = make_q;
  assign break_pulse = brk_q;
  assign code_en     = code_en_q;
  assign cnt_en      = cnt_en_q;
  assign err         = err_q;

endmodule

// File: tb/tb_kbd_ctrl.sv
// Directed testbench for kbd_ctrl with a short timeout.
module tb_kbd_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       code_valid;
  logic [7:0] code;
  logic       err_clr;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_held;
  logic [7:0] press_count;
  logic       make_pulse;
  logic       break_pulse;
  logic       code_en;
  logic       cnt_en;
  logic       err;

  int errors = 0;
  int checks = 0;
  int make_cnt = 0;
  int brk_cnt = 0;
  int both_cnt = 0;

  kbd_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn), .code_valid(code_valid), .code(code),
    .err_clr(err_clr), .key_code(key_code), .key_ext(key_ext),
    .key_held(key_held), .press_count(press_count), .make_pulse(make_pulse),
    .break_pulse(break_pulse), .code_en(code_en), .cnt_en(cnt_en), .err(err)
  );

  always #5 clk = ~clk;

  // Pulse tallies, sampled away from the active edge
  always @(negedge clk) begin
    if (make_pulse) make_cnt++;
    if (break_pulse) brk_cnt++;
    if (make_pulse && break_pulse) both_cnt++;
  end

  // Called at a negedge; returns at the next negedge with outputs updated.
  task automatic send(input logic [7:0] b);
    code_valid = 1'b1;
    code = b;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    code_valid = 1'b0;
    code = 8'h00;
    err_clr = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (key_code !== 8'h00) begin errors++; $display("FAIL rst_key_code got=%h exp=00", key_code); end
    checks++; if (key_ext !== 1'b0) begin errors++; $display("FAIL rst_key_ext got=%b exp=0", key_ext); end
    checks++; if (key_held !== 1'b0 || code_en !== 1'b0) begin errors++; $display("FAIL rst_held got=%b/%b exp=0/0", key_held, code_en); end
    checks++; if (press_count !== 8'h00) begin errors++; $display("FAIL rst_press got=%h exp=00", press_count); end
    checks++; if (make_pulse !== 1'b0 || break_pulse !== 1'b0) begin errors++; $display("FAIL rst_pulses got=%b/%b exp=0/0", make_pulse, break_pulse); end
    checks++; if (cnt_en !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_cnt_en_err got=%b/%b exp=0/0", cnt_en, err); end
  endtask

  task automatic test_make_break();
    int m0, b0;
    do_reset();
    m0 = make_cnt; b0 = brk_cnt;
    send(8'h1C);
    checks++; if (key_code !== 8'h1C || key_ext !== 1'b0) begin errors++; $display("FAIL mb_key got=%h/%b exp=1c/0", key_code, key_ext); end
    checks++; if (key_held !== 1'b1 || code_en !== 1'b1) begin errors++; $display("FAIL mb_held got=%b/%b exp=1/1", key_held, code_en); end
    checks++; if (press_count !== 8'h01 || make_pulse !== 1'b1 || cnt_en !== 1'b1) begin errors++; $display("FAIL mb_press got=%h/%b/%b exp=01/1/1", press_count, make_pulse, cnt_en); end
    send(8'hF0);
    checks++; if (key_held !== 1'b1 || make_pulse !== 1'b0) begin errors++; $display("FAIL mb_prefix got=%b/%b exp=1/0", key_held, make_pulse); end
    send(8'h1C);
    checks++; if (key_held !== 1'b0 || code_en !== 1'b0 || break_pulse !== 1'b1) begin errors++; $display("FAIL mb_release got=%b/%b/%b exp=0/0/1", key_held, code_en, break_pulse); end
    checks++; if (cnt_en !== 1'b1 || key_code !== 8'h1C) begin errors++; $display("FAIL mb_after got=%b/%h exp=1/1c", cnt_en, key_code); end
    idle(2);
    checks++; if (make_cnt - m0 !== 1 || brk_cnt - b0 !== 1) begin errors++; $display("FAIL mb_pulse_cnt got=%0d/%0d exp=1/1", make_cnt - m0, brk_cnt - b0); end
  endtask

  task automatic test_typematic();
    int m0, b0;
    do_reset();
    m0 = make_cnt; b0 = brk_cnt;
    send(8'h1C); send(8'h1C); send(8'h1C);
    checks++; if (press_count !== 8'h01 || key_held !== 1'b1) begin errors++; $display("FAIL typ_press got=%h/%b exp=01/1", press_count, key_held); end
    send(8'hF0); send(8'h1C);
    idle(2);
    checks++; if (make_cnt - m0 !== 1 || brk_cnt - b0 !== 1 || key_held !== 1'b0) begin errors++; $display("FAIL typ_pulses got=%0d/%0d/%b exp=1/1/0", make_cnt - m0, brk_cnt - b0, key_held); end
  endtask

  task automatic test_extended();
    do_reset();
    send(8'hE0); send(8'h75);
    checks++; if (key_code !== 8'h75 || key_ext !== 1'b1 || key_held !== 1'b1 || press_count !== 8'h01) begin errors++; $display("FAIL ext_make got=%h/%b/%b/%h exp=75/1/1/01", key_code, key_ext, key_held, press_count); end
    send(8'hF0); send(8'h75);
    checks++; if (key_held !== 1'b1 || break_pulse !== 1'b0) begin errors++; $display("FAIL ext_plain_break got=%b/%b exp=1/0", key_held, break_pulse); end
    send(8'hE0); send(8'hF0); send(8'h75);
    checks++; if (key_held !== 1'b0 || break_pulse !== 1'b1 || press_count !== 8'h01 || err !== 1'b0) begin errors++; $display("FAIL ext_break got=%b/%b/%h/%b exp=0/1/01/0", key_held, break_pulse, press_count, err); end
    // A different key while one is held replaces it and counts
    send(8'h1C); send(8'h2A);
    checks++; if (key_code !== 8'h2A || press_count !== 8'h03 || key_held !== 1'b1) begin errors++; $display("FAIL ext_replace got=%h/%h/%b exp=2a/03/1", key_code, press_count, key_held); end
  endtask

  task automatic test_wrap();
    int m0;
    logic [7:0] c;
    do_reset();
    m0 = make_cnt;
    for (int i = 0; i < 256; i++) begin
      c = 8'((i % 112) + 1);
      send(c); send(8'hF0); send(c);
      if (i == 254) begin
        checks++; if (press_count !== 8'hFF) begin errors++; $display("FAIL wrap_ff got=%h exp=ff", press_count); end
      end
    end
    idle(2);
    checks++; if (press_count !== 8'h00 || make_cnt - m0 !== 256) begin errors++; $display("FAIL wrap_00 got=%h/%0d exp=00/256", press_count, make_cnt - m0); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL pulses_overlap got=%0d exp=0", both_cnt); end
  endtask

  task automatic test_proto_err();
    int m0, b0;
    do_reset();
    m0 = make_cnt; b0 = brk_cnt;
    send(8'hF0); send(8'hF0);
    idle(2);
    checks++; if (err !== 1'b1 || make_cnt - m0 !== 0 || brk_cnt - b0 !== 0) begin errors++; $display("FAIL perr_set got=%b/%0d/%0d exp=1/0/0", err, make_cnt - m0, brk_cnt - b0); end
    send(8'h1C);
    checks++; if (key_code !== 8'h1C || key_ext !== 1'b0 || press_count !== 8'h01) begin errors++; $display("FAIL perr_idle got=%h/%b/%h exp=1c/0/01", key_code, key_ext, press_count); end
    send(8'hF0);
    err_clr = 1'b1;
    send(8'hE0);
    err_clr = 1'b0;
    checks++; if (err !== 1'b1 || key_held !== 1'b1) begin errors++; $display("FAIL perr_set_wins got=%b/%b exp=1/1", err, key_held); end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL perr_clear got=%b exp=0", err); end
    send(8'hE0); send(8'hE0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL perr_ext_e0 got=%b exp=1", err); end
    send(8'h33);
    checks++; if (key_code !== 8'h33 || key_ext !== 1'b1) begin errors++; $display("FAIL perr_ext_stay got=%h/%b exp=33/1", key_code, key_ext); end
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'hE0);
    idle(7);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_early got=%b exp=0", err); end
    idle(1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_fire got=%b exp=1", err); end
    send(8'h1C);
    checks++; if (key_code !== 8'h1C || key_ext !== 1'b0 || press_count !== 8'h01) begin errors++; $display("FAIL tmo_after got=%h/%b/%h exp=1c/0/01", key_code, key_ext, press_count); end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    // Strobe on the expiring cycle cancels the timeout
    send(8'hE0);
    idle(7);
    send(8'h44);
    checks++; if (err !== 1'b0 || key_code !== 8'h44 || key_ext !== 1'b1) begin errors++; $display("FAIL tmo_cancel got=%b/%h/%b exp=0/44/1", err, key_code, key_ext); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h1C);
    send(8'hE0); send(8'hF0);
    #2 resetn = 1'b0;
    #1;
    checks++; if (key_code !== 8'h00 || key_held !== 1'b0 || code_en !== 1'b0 || press_count !== 8'h00 || cnt_en !== 1'b0 || err !== 1'b0 || key_ext !== 1'b0 || make_pulse !== 1'b0 || break_pulse !== 1'b0) begin
      errors++; $display("FAIL mid_reset got=%h/%b/%b/%h/%b/%b exp=00/0/0/00/0/0", key_code, key_held, code_en, press_count, cnt_en, err);
    end
    @(negedge clk);
    resetn = 1'b1;
    idle(1);
    send(8'h75);
    checks++; if (key_code !== 8'h75 || key_ext !== 1'b0 || key_held !== 1'b1) begin errors++; $display("FAIL mid_reset_lost got=%h/%b/%b exp=75/0/1", key_code, key_ext, key_held); end
  endtask

  initial begin
    resetn = 1'b0;
    code_valid = 1'b0;
    code = 8'h00;
    err_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_make_break();
    test_typematic();
    test_extended();
    test_wrap();
    test_proto_err();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kbd_ctrl.md
# kbd_ctrl

Scan-code sequencer between the PS/2 keyboard receiver and the seven-segment display drivers. It consumes the receiver's byte stream and decodes the PS/2 set-2 prefix protocol (E0 extended, F0 break) with a four-state FSM. It tracks the currently held key, suppresses typematic repeats and counts key presses. It drives the display-enable controls, so code digits are blanked on release and the count digits are lit after the first press.

## Interface
Parameters:
- TIMEOUT, default 1000000: number of idle clk cycles allowed inside a prefix sequence before it is abandoned; must be ≥ 2.
- CW, default $clog2(TIMEOUT+1): width of the timeout counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- code_valid  input  1  one-cycle strobe from the receiver; code is valid while high.
- code  input  8  received scan byte.
- err_clr  input  1  clears the sticky error flag.
- key_code  output  8  last make code accepted (prefix bytes excluded).
- key_ext  output  1  key_code came from an E0-prefixed sequence.
- key_held  output  1  key_code/key_ext is currently pressed.
- press_count  output  8  number of accepted new presses, modulo 256.
- make_pulse  output  1  one-cycle pulse on each accepted new press.
- break_pulse  output  1  one-cycle pulse on release of the held key.
- code_en  output  1  enable for the code digits; equals key_held.
- cnt_en  output  1  enable for the count digits; set on the first press, cleared only by reset.
- err  output  1  sticky protocol or timeout error.

## Operation
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). The FSM only evaluates when code_valid=1.
- Transitions from IDLE:
  - E0 goes to EXT.
  - F0 goes to BRK.
  - Any other byte is a MAKE(code, ext=0); the FSM stays in IDLE.
- Transitions from EXT:
  - F0 goes to EXT_BRK.
  - E0 is an error; the FSM stays in EXT.
  - Any other byte is a MAKE(code, ext=1); the FSM goes to IDLE.
- Transitions from BRK:
  - E0 or F0 is an error; the FSM goes to IDLE.
  - Any other byte is a BREAK(code, ext=0); the FSM goes to IDLE.
- Transitions from EXT_BRK:
  - E0 or F0 is an error; the FSM goes to IDLE.
  - Any other byte is a BREAK(code, ext=1); the FSM goes to IDLE.
- MAKE action:
  - If key_held=1 and (code, ext) equals (key_code, key_ext), the byte is a typematic repeat: no output changes.
  - Otherwise: key_code←code, key_ext←ext, key_held←1, press_count←press_count+1 (255 wraps to 0), make_pulse=1, cnt_en←1.
- BREAK action:
  - If key_held=1 and (code, ext) matches: key_held←0 and break_pulse=1.
  - Otherwise the break is ignored; no output changes and no error.
- A new different make while a key is held replaces the held key and counts as a press.
- Timeout:
  - The counter resets to 0 on every code_valid and whenever the FSM is in IDLE.
  - Otherwise the counter increments each cycle.
  - When it reaches TIMEOUT with no code_valid, the FSM goes to IDLE and err←1.
  - The partial sequence is discarded with no make or break.
- Error flag:
  - err is set by any error event.
  - err_clr=1 clears it.
  - If a set and a clear occur in the same cycle, set wins.

## Timing
- Reset state (asynchronous, while resetn=0): FSM=IDLE, timeout counter=0, key_code=00, key_ext=0, key_held=0, press_count=00, make_pulse=0, break_pulse=0, code_en=0, cnt_en=0, err=0.
- Latency: every output reflects a byte on the rising edge that samples code_valid=1, so it is visible one cycle after the strobe.
- make_pulse and break_pulse are high for exactly one cycle and are never both high in the same cycle.
- Back-to-back code_valid on consecutive cycles is fully supported; every byte is processed and there is no backpressure.
- code_en is a registered copy of key_held with the same timing as key_held (not delayed further).
- Timeout event: with the last byte at edge N and no further strobes, the state returns to IDLE and err=1 after edge N+TIMEOUT.
- If code_valid arrives on the same cycle the counter would expire, the byte is processed and the timeout is cancelled.
- Asserting resetn=0 mid-sequence (for example in EXT_BRK) forces the reset state immediately. Any partial sequence is lost.

## Test plan
- Reset, then bytes 1C, F0, 1C → key_code=1C, key_ext=0; press_count 00→01; make_pulse once; key_held/code_en 1 then 0; break_pulse once; cnt_en stays 1.
- Bytes 1C, 1C, 1C (typematic), then F0 1C → press_count=01; make_pulse exactly once; break_pulse exactly once.
- Bytes E0 75, then E0 F0 75 → key_code=75, key_ext=1, press_count=01, key_held returns to 0. A plain F0 75 instead leaves key_held=1.
- 256 distinct make/break pairs → press_count wraps to 00; make_pulse count is 256.
- Prefix protocol errors:
  - Bytes F0, F0 → err=1, FSM back in IDLE, no pulses.
  - err_clr pulsed in the same cycle as a new error → err stays 1.
  - err_clr alone → err=0.
- TIMEOUT=8, byte E0 then silence → err=1 eight cycles after E0 is accepted. A following 1C is then a MAKE with ext=0. Also drop resetn mid-EXT_BRK → all outputs at reset values immediately.
